// File: rtl/qc_seq_pkg.sv
// Shared definitions for the Q-Control parameter sequencer.
//   - qc_seq_state_e : sequencer FSM encoding, also exported on the status port
//   - DefGainWidth / DefDelayLen2 : widths matching the Q-Control mixer
//   - step_toward()  : one clamped slew step of a signed value toward a target
package qc_seq_pkg;

  localparam int unsigned DefGainWidth = 16;
  localparam int unsigned DefDelayLen2 = 13;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StRampDown = 3'd1,
    StSetDelay = 3'd2,
    StSettle   = 3'd3,
    StRampUp   = 3'd4,
    StRun      = 3'd5
  } qc_seq_state_e;

  // Moves cur toward tgt by step, landing exactly on tgt when within one step,
  // so a ramp never overshoots or crosses past the target. Operands are carried
  // sign-extended in 32 bits; the 33-bit difference covers any pair of gains up
  // to 31 bits, including the most negative value.
  function automatic logic signed [31:0] step_toward(input logic signed [31:0] cur,
                                                     input logic signed [31:0] tgt,
                                                     input logic [15:0]        step);
    logic signed [32:0] diff;
    logic        [32:0] mag;
    diff = 33'(tgt) - 33'(cur);
    mag  = diff[32] ? 33'(-diff) : 33'(diff);
    if (mag <= 33'(step)) begin
      return tgt;
    end
    if (diff[32]) begin
      return cur - $signed(32'(step));
    end
    return cur + $signed(32'(step));
  endfunction

endpackage

// File: rtl/qc_tick_gen.sv
// Decimated sample tick for the Q-Control path.
// A free-running DECII_LEN2-bit counter; tick is high for the one a_clk cycle
// in every 2^DECII_LEN2 where the counter is all-ones. Kept as its own block so
// the mixer can share the exact same tick.
// Ports:
//   a_clk    : clock
//   a_resetn : asynchronous active-low reset, counter returns to 0
//   tick     : one-cycle sample tick
module qc_tick_gen
  import qc_seq_pkg::*;
#(
  parameter int unsigned DECII_LEN2 = 2
) (
  input  logic a_clk,
  input  logic a_resetn,
  output logic tick
);

  logic [DECII_LEN2-1:0] cnt_q;

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DECII_LEN2'(1);
    end
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/qc_param_sequencer.sv
// Q-Control parameter sequencer.
// Applies host configuration (enable, gain, delay) to the Q-Control mixer
// without glitching the actuator drive: gain is slewed per sample tick, the
// delay only changes while gain is zero, and a delay change is followed by a
// settle period long enough to refill the delay line.
//
// Build option: define QC_SEQ_GAIN_LIMIT_EN to add the gain_limit input and the
// sticky limit_hit output; the accepted gain is saturated to +/-gain_limit.
//
// Ports:
//   a_clk, a_resetn          : clock, asynchronous active-low reset
//   cfg_enable/gain/delay    : requested settings (low DELAY_LEN2 delay bits used)
//   cfg_step                 : gain slew per tick, 0 behaves as 1
//   cfg_valid / cfg_ready    : request handshake, only ready in OFF and RUN
//   gain_limit, limit_hit    : optional gain saturation and its sticky flag
//   QC_enable/gain/delay     : mixer configuration
//   busy                     : sequencing in progress
//   state                    : FSM state for status readback
module qc_param_sequencer
  import qc_seq_pkg::*;
#(
  parameter int unsigned GAIN_WIDTH   = DefGainWidth,
  parameter int unsigned DELAY_LEN2   = DefDelayLen2,
  parameter int unsigned DECII_LEN2   = 2,
  parameter int unsigned SETTLE_TICKS = 8192
) (
  input  logic                         a_clk,
  input  logic                         a_resetn,
  input  logic                         cfg_enable,
  input  logic signed [GAIN_WIDTH-1:0] cfg_gain,
  input  logic [15:0]                  cfg_delay,
  input  logic [15:0]                  cfg_step,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
`ifdef QC_SEQ_GAIN_LIMIT_EN
  input  logic [GAIN_WIDTH-2:0]        gain_limit,
  output logic                         limit_hit,
`endif
  output logic                         QC_enable,
  output logic signed [GAIN_WIDTH-1:0] QC_gain,
  output logic [15:0]                  QC_delay,
  output logic                         busy,
  output logic [2:0]                   state
);

  localparam int unsigned SettleW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  qc_seq_state_e                state_q, state_d;
  logic                         qc_enable_q, qc_enable_d;
  logic signed [GAIN_WIDTH-1:0] qc_gain_q, qc_gain_d;
  logic [DELAY_LEN2-1:0]        qc_delay_q, qc_delay_d;
  logic                         tgt_enable_q, tgt_enable_d;
  logic signed [GAIN_WIDTH-1:0] tgt_gain_q, tgt_gain_d;
  logic [DELAY_LEN2-1:0]        tgt_delay_q, tgt_delay_d;
  logic [15:0]                  step_q, step_d;
  logic [SettleW-1:0]           settle_q, settle_d;

  logic                         tick;
  logic                         accept;
  logic signed [GAIN_WIDTH-1:0] acc_gain;
  logic                         acc_clamp;
  logic [DELAY_LEN2-1:0]        acc_delay;
  logic signed [GAIN_WIDTH-1:0] down_gain;
  logic signed [GAIN_WIDTH-1:0] up_gain;

  qc_tick_gen #(
    .DECII_LEN2(DECII_LEN2)
  ) u_tick_gen (
    .a_clk   (a_clk),
    .a_resetn(a_resetn),
    .tick    (tick)
  );

  assign accept    = cfg_valid && cfg_ready;
  assign acc_delay = cfg_delay[DELAY_LEN2-1:0];

  if (DELAY_LEN2 < 16) begin : g_delay_hi
    logic unused_delay_hi;
    assign unused_delay_hi = ^cfg_delay[15:DELAY_LEN2];
  end

`ifdef QC_SEQ_GAIN_LIMIT_EN
  logic signed [31:0] gain_ext;
  logic signed [31:0] lim_ext;
  logic               limit_hit_q, limit_hit_d;

  assign gain_ext = 32'(cfg_gain);
  assign lim_ext  = $signed(32'(gain_limit));

  always_comb begin
    acc_gain  = cfg_gain;
    acc_clamp = 1'b0;
    if (gain_ext > lim_ext) begin
      acc_gain  = GAIN_WIDTH'(lim_ext);
      acc_clamp = 1'b1;
    end else if (gain_ext < -lim_ext) begin
      acc_gain  = GAIN_WIDTH'(-lim_ext);
      acc_clamp = 1'b1;
    end
  end

  // Sticky until an accept that stays within the limit.
  assign limit_hit_d = accept ? acc_clamp : limit_hit_q;
  assign limit_hit   = limit_hit_q;

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      limit_hit_q <= 1'b0;
    end else begin
      limit_hit_q <= limit_hit_d;
    end
  end
`else
  assign acc_gain  = cfg_gain;
  assign acc_clamp = 1'b0;
  logic unused_acc_clamp;
  assign unused_acc_clamp = acc_clamp;
`endif

  // Candidate gains for one slew step; only applied on a tick.
  assign down_gain = GAIN_WIDTH'(step_toward(32'(qc_gain_q), 32'sd0, step_q));
  assign up_gain   = GAIN_WIDTH'(step_toward(32'(qc_gain_q), 32'(tgt_gain_q), step_q));

  always_comb begin
    state_d      = state_q;
    qc_enable_d  = qc_enable_q;
    qc_gain_d    = qc_gain_q;
    qc_delay_d   = qc_delay_q;
    tgt_enable_d = tgt_enable_q;
    tgt_gain_d   = tgt_gain_q;
    tgt_delay_d  = tgt_delay_q;
    step_d       = step_q;
    settle_d     = settle_q;

    if (accept) begin
      tgt_enable_d = cfg_enable;
      tgt_gain_d   = acc_gain;
      tgt_delay_d  = acc_delay;
      step_d       = (cfg_step == '0) ? 16'd1 : cfg_step;
    end

    unique case (state_q)
      StOff: begin
        if (accept && cfg_enable) begin
          state_d = StSetDelay;
        end
      end
      StRun: begin
        if (accept) begin
          // A delay change or disable must first bring the drive to zero.
          if (!cfg_enable || (acc_delay != qc_delay_q)) begin
            state_d = StRampDown;
          end else begin
            state_d = StRampUp;
          end
        end
      end
      StRampDown: begin
        if (qc_gain_q == '0) begin
          if (!tgt_enable_q) begin
            qc_enable_d = 1'b0;
            state_d     = StOff;
          end else begin
            state_d = StSetDelay;
          end
        end else if (tick) begin
          qc_gain_d = down_gain;
        end
      end
      StSetDelay: begin
        qc_delay_d  = tgt_delay_q;
        qc_enable_d = 1'b1;
        settle_d    = SettleW'(SETTLE_TICKS - 1);
        state_d     = StSettle;
      end
      StSettle: begin
        if (tick) begin
          if (settle_q == '0) begin
            state_d = StRampUp;
          end else begin
            settle_d = settle_q - SettleW'(1);
          end
        end
      end
      StRampUp: begin
        if (qc_gain_q == tgt_gain_q) begin
          state_d = StRun;
        end else if (tick) begin
          qc_gain_d = up_gain;
        end
      end
      default: begin
        state_d = StOff;
      end
    endcase
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q      <= StOff;
      qc_enable_q  <= 1'b0;
      qc_gain_q    <= '0;
      qc_delay_q   <= '0;
      tgt_enable_q <= 1'b0;
      tgt_gain_q   <= '0;
      tgt_delay_q  <= '0;
      step_q       <= 16'd1;
      settle_q     <= '0;
    end else begin
      state_q      <= state_d;
      qc_enable_q  <= qc_enable_d;
      qc_gain_q    <= qc_gain_d;
      qc_delay_q   <= qc_delay_d;
      tgt_enable_q <= tgt_enable_d;
      tgt_gain_q   <= tgt_gain_d;
      tgt_delay_q  <= tgt_delay_d;
      step_q       <= step_d;
      settle_q     <= settle_d;
    end
  end

  assign cfg_ready = (state_q == StOff) || (state_q == StRun);
  assign busy      = (state_q == StRampDown) || (state_q == StSetDelay) ||
                     (state_q == StSettle)   || (state_q == StRampUp);
  assign state     = state_q;
  assign QC_enable = qc_enable_q;
  assign QC_gain   = qc_gain_q;
  assign QC_delay  = 16'(qc_delay_q);

endmodule

// File: tb/tb_qc_param_sequencer.sv
// Self-checking bench for qc_param_sequencer. A transaction-level model turns
// each accepted request into the expected list of visited states and gain
// values; a monitor compares every observed state/gain change against it.
module tb_qc_param_sequencer;

  localparam int SETTLE = 16;
  localparam int DECII  = 4;

  typedef logic signed [31:0] val_t;

  logic              a_clk = 1'b0;
  logic              a_resetn = 1'b0;
  logic              cfg_enable = 1'b0;
  logic signed [15:0] cfg_gain = '0;
  logic [15:0]       cfg_delay = '0;
  logic [15:0]       cfg_step = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic              qc_enable;
  logic signed [15:0] qc_gain;
  logic [15:0]       qc_delay;
  logic              busy;
  logic [2:0]        state;
`ifdef QC_SEQ_GAIN_LIMIT_EN
  logic [14:0]       gain_limit = '1;
  logic              limit_hit;
  int                m_lim = 0;
`endif

  always #5 a_clk = ~a_clk;

  qc_param_sequencer #(
    .GAIN_WIDTH  (16),
    .DELAY_LEN2  (13),
    .DECII_LEN2  (2),
    .SETTLE_TICKS(SETTLE)
  ) dut (
    .a_clk     (a_clk),
    .a_resetn  (a_resetn),
    .cfg_enable(cfg_enable),
    .cfg_gain  (cfg_gain),
    .cfg_delay (cfg_delay),
    .cfg_step  (cfg_step),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
`ifdef QC_SEQ_GAIN_LIMIT_EN
    .gain_limit(gain_limit),
    .limit_hit (limit_hit),
`endif
    .QC_enable (qc_enable),
    .QC_gain   (qc_gain),
    .QC_delay  (qc_delay),
    .busy      (busy),
    .state     (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Model of the applied settings and the expected change sequence.
  int m_run = 0, m_en = 0, m_gain = 0, m_delay = 0, exp_delay = 0;
  bit m_fast = 1'b0;
  int exp_state[$];
  int exp_gain[$];

  // Monitor history.
  logic [2:0]         p_state = '0;
  logic signed [15:0] p_gain = '0;
  logic [15:0]        p_delay = '0;
  logic               p_en = 1'b0;
  int edge_cnt = 0, settle_ticks = 0, up_edge = 0;

  function automatic void push_ramp(input int from, input int to, input int s);
    int g;
    g = from;
    while (g != to) begin
      if ((to - g <= s) && (g - to <= s)) g = to;
      else if (to > g) g = g + s;
      else g = g - s;
      exp_gain.push_back(g);
    end
  endfunction

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_enable"}, val_t'(qc_enable), 0);
    check_eq({pfx, "_gain"}, val_t'(qc_gain), 0);
    check_eq({pfx, "_delay"}, val_t'(qc_delay), 0);
    check_eq({pfx, "_ready"}, val_t'(cfg_ready), 1);
    check_eq({pfx, "_busy"}, val_t'(busy), 0);
    check_eq({pfx, "_state"}, val_t'(state), 0);
`ifdef QC_SEQ_GAIN_LIMIT_EN
    check_eq({pfx, "_limit_hit"}, val_t'(limit_hit), 0);
`endif
  endtask

  // Asserted away from any clock edge; outputs must clear without a clock.
  task automatic apply_reset(input string pfx);
    a_resetn = 1'b0;
    #1;
    check_reset_vals(pfx);
    exp_state.delete();
    exp_gain.delete();
    m_run = 0; m_en = 0; m_gain = 0; m_delay = 0; exp_delay = 0; m_fast = 1'b0;
`ifdef QC_SEQ_GAIN_LIMIT_EN
    m_lim = 0;
`endif
    p_state = '0; p_gain = '0; p_delay = '0; p_en = 1'b0;
    edge_cnt = 0; settle_ticks = 0; up_edge = 0;
    repeat (2) @(negedge a_clk);
    a_resetn = 1'b1;
  endtask

  task automatic check_settled();
    check_eq("pending_states", val_t'(exp_state.size()), 0);
    check_eq("pending_gains", val_t'(exp_gain.size()), 0);
    check_eq("QC_enable", val_t'(qc_enable), val_t'(m_en));
    check_eq("QC_gain", val_t'(qc_gain), val_t'(m_gain));
    check_eq("QC_delay", val_t'(qc_delay), val_t'(m_delay));
    check_eq("idle_state", val_t'(state), m_run ? 5 : 0);
`ifdef QC_SEQ_GAIN_LIMIT_EN
    check_eq("limit_hit", val_t'(limit_hit), val_t'(m_lim));
`endif
  endtask

  // Called at a negedge; returns with ok=1 once cfg_ready is seen.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      check_eq("busy_flag", val_t'(busy), val_t'(state inside {3'd1, 3'd2, 3'd3, 3'd4}));
      check_eq("ready_flag", val_t'(cfg_ready), val_t'(state == 3'd0 || state == 3'd5));
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge a_clk);
    end
    if (!ok) check_eq("ready_timeout", val_t'(cfg_ready), 1);
  endtask

  // Presents a request and holds valid until accepted.
  task automatic do_req(input bit en, input int gain, input int delay, input int step);
    int g, d, s;
    bit ok;
    @(negedge a_clk);
    cfg_enable = en;
    cfg_gain   = 16'(gain);
    cfg_delay  = 16'(delay);
    cfg_step   = 16'(step);
    cfg_valid  = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      cfg_valid = 1'b0;
      return;
    end
    check_settled();
    g = gain;
`ifdef QC_SEQ_GAIN_LIMIT_EN
    m_lim = 0;
    if (g < -32767) begin
      g = -32767;
      m_lim = 1;
    end
`endif
    d = delay & 'h1fff;
    s = ((step & 'hffff) == 0) ? 1 : (step & 'hffff);
    if (m_run == 0) begin
      if (en) begin
        exp_state.push_back(2); exp_state.push_back(3);
        exp_state.push_back(4); exp_state.push_back(5);
        push_ramp(0, g, s);
        m_fast = (g == 0);
        m_run = 1; m_en = 1; m_gain = g; m_delay = d;
      end
    end else if (!en || d != m_delay) begin
      exp_state.push_back(1);
      push_ramp(m_gain, 0, s);
      if (!en) begin
        exp_state.push_back(0);
        m_run = 0; m_en = 0; m_gain = 0;
      end else begin
        exp_state.push_back(2); exp_state.push_back(3);
        exp_state.push_back(4); exp_state.push_back(5);
        push_ramp(0, g, s);
        m_fast = (g == 0);
        m_gain = g; m_delay = d;
      end
    end else begin
      exp_state.push_back(4); exp_state.push_back(5);
      push_ramp(m_gain, g, s);
      m_fast = (m_gain == g);
      m_gain = g;
    end
    exp_delay = m_delay;
    @(posedge a_clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Monitor: every change on state/gain/delay/enable is checked as it happens.
  initial begin
    bit tick_edge;
    forever begin
      @(posedge a_clk);
      #1;
      if (a_resetn) begin
        edge_cnt++;
        tick_edge = (edge_cnt % DECII == 0);
        if (p_state == 3'd3 && tick_edge) settle_ticks++;
        if (state != p_state) begin
          if (exp_state.size() == 0) check_eq("state_unexpected", val_t'(state), val_t'(p_state));
          else check_eq("state_seq", val_t'(state), val_t'(exp_state.pop_front()));
          if (p_state == 3'd3 && state == 3'd4) check_eq("settle_ticks", settle_ticks, SETTLE);
          if (p_state == 3'd4 && state == 3'd5 && m_fast)
            check_eq("fast_rampup_cycles", val_t'(edge_cnt - up_edge), 1);
          if (state == 3'd3) settle_ticks = 0;
          if (state == 3'd4) up_edge = edge_cnt;
        end
        if (qc_gain != p_gain) begin
          if (exp_gain.size() == 0) check_eq("gain_unexpected", val_t'(qc_gain), val_t'(p_gain));
          else check_eq("gain_step", val_t'(qc_gain), val_t'(exp_gain.pop_front()));
          check_eq("gain_tick_align", val_t'(edge_cnt % DECII), 0);
        end
        if (qc_delay != p_delay) begin
          check_eq("delay_at_zero_gain", val_t'(qc_gain), 0);
          check_eq("delay_value", val_t'(qc_delay), val_t'(exp_delay));
        end
        if (p_en && !qc_enable) check_eq("disable_at_zero_gain", val_t'(qc_gain), 0);
        p_state = state;
        p_gain  = qc_gain;
        p_delay = qc_delay;
        p_en    = qc_enable;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int en, gain, delay, step, r;
    logic [15:0] r16;
    #1;
    check_reset_vals("por");
    @(negedge a_clk);
    a_resetn = 1'b1;

    do_req(1, 1000, 100, 250);   // OFF -> ramp 250..1000
    do_req(1, 1000, 200, 250);   // delay change: down, settle, up
    do_req(1, -700, 200, 500);   // same delay, sign crossing ramp
    do_req(1, 1000, 200, 4000);
    do_req(0, 1000, 200, 0);     // step 0 acts as 1, then disable
    do_req(1, 300, 5, 100);
    do_req(1, 300, 5, 100);      // unchanged request, one-cycle RAMP_UP
    do_req(1, 300, 9, 100);
    do_req(1, -300, 9, 200);     // held while the previous one is busy
    do_req(1, -32768, 9, 65535);
    do_req(1, 32767, 9, 65535);
    do_req(1, -32768, 9, 40000);

    // Reset in the middle of a ramp-up.
    do_req(1, 20000, 321, 3000);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge a_clk);
      if (state == 3'd4) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("reached_rampup", val_t'(state), 4);
    repeat (5) @(negedge a_clk);
    check_eq("pre_reset_busy", val_t'(busy), 1);
    #2;
    apply_reset("mid_reset");
    do_req(1, 1234, 77, 300);

    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 4) != 0) ? 1 : 0;
      if (m_run != 0 && $urandom_range(0, 1) == 1) delay = m_delay + ($urandom_range(0, 7) << 13);
      else delay = $urandom_range(0, 65535);
      r = $urandom_range(0, 9);
      r16 = 16'($urandom);
      if (r == 0) gain = -32768;
      else if (r == 1) gain = 32767;
      else gain = int'($signed(r16));
      if ($urandom_range(0, 5) == 0 && m_gain <= 40 && m_gain >= -40) begin
        step = 0;
        gain = $urandom_range(0, 60) - 30;
      end else begin
        step = $urandom_range(2048, 65535);
      end
      do_req(en[0], gain, delay, step);
    end

    @(negedge a_clk);
    wait_ready(ok);
    if (ok) check_settled();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qc_param_sequencer.md
Name: qc_param_sequencer

Overview:
Sequences the configuration inputs (QC_enable, QC_gain, QC_delay) of the Q-Control mixer so host changes never glitch the actuator drive. Gain is slewed in steps on the mixer's decimated sample tick. Delay changes only while gain is zero, followed by a delay-line settle period. Sits between the host config registers and the Q-Control mixer in the a_clk domain.

Parameters:
GAIN_WIDTH, 16, signed gain width (matches mixer QC_gain)
DELAY_LEN2, 13, delay index width (matches mixer QC_PHASE_LEN2)
DECII_LEN2, 2, log2 of a_clk cycles per sample tick
SETTLE_TICKS, 8192, ticks to wait after a delay change (one full delay-line refill)

Ports:
a_clk  in  1  clock
a_resetn  in  1  asynchronous active-low reset
cfg_enable  in  1  requested Q-control enable
cfg_gain  in  GAIN_WIDTH  requested signed gain
cfg_delay  in  16  requested delay; low DELAY_LEN2 bits used
cfg_step  in  16  unsigned gain slew per tick; 0 treated as 1
cfg_valid  in  1  request valid
cfg_ready  out  1  request accepted when valid&&ready
QC_enable  out  1  to mixer
QC_gain  out  GAIN_WIDTH  to mixer
QC_delay  out  16  to mixer, upper bits zero
busy  out  1  sequencing in progress
state  out  3  FSM state for status readback

Behaviour:
- Clock and reset: one clock a_clk; reset a_resetn is asynchronous, active-low.
- Reset values (asynchronous): QC_enable=0, QC_gain=0, QC_delay=0, cfg_ready=1, busy=0, state=OFF, tick counter=0, settle counter=0.
- Tick: a free-running DECII_LEN2-bit counter asserts tick in the cycle it equals all-ones, i.e. 1 in 2^DECII_LEN2 cycles.
- States: OFF=0, RAMP_DOWN=1, SET_DELAY=2, SETTLE=3, RAMP_UP=4, RUN=5. busy=1 in states 1-4. cfg_ready=1 only in OFF and RUN.
- Accept:
  - On cfg_valid&&cfg_ready, capture tgt_enable, tgt_gain, tgt_delay and step (0 becomes 1) in that cycle.
  - Next state from OFF: if tgt_enable=1, go to SET_DELAY; else stay OFF.
  - Next state from RUN: if tgt_enable=0 or tgt_delay differs from QC_delay, go to RAMP_DOWN; else go to RAMP_UP (slew to the new gain in either direction).
- RAMP_DOWN: on each tick, QC_gain moves toward 0 by step and clamps at 0 (no sign crossing). The state checks QC_gain==0 every cycle. When 0: if tgt_enable=0, QC_enable<=0 and go to OFF; else go to SET_DELAY.
- SET_DELAY: one cycle. QC_delay<=tgt_delay, QC_enable<=1, settle counter<=SETTLE_TICKS-1, then go to SETTLE.
- SETTLE: the counter decrements on tick. On the tick where it reads 0, go to RAMP_UP. QC_gain stays 0 throughout.
- RAMP_UP: on each tick, compute diff=tgt_gain-QC_gain in GAIN_WIDTH+1 signed bits. If |diff|<=step, QC_gain<=tgt_gain; else QC_gain+=sign(diff)*step. When QC_gain==tgt_gain (checked every cycle), go to RUN.
- Latency: state and outputs update on the clock edge after the triggering condition.
- Boundaries:
  - cfg_valid while busy is ignored; the requester holds valid.
  - A request equal to current settings in RUN passes RAMP_UP to RUN in 1 cycle.
  - Gain -32768 is handled by the 17-bit diff.
  - Async reset mid-ramp forces the reset values immediately.

Optional Feature:
QC_SEQ_GAIN_LIMIT_EN.
- Defined: adds input gain_limit[GAIN_WIDTH-2:0] (unsigned). Captured tgt_gain is saturated to ±gain_limit at accept, and the sticky output limit_hit asserts when clamping occurred. limit_hit clears on the next accept that does not clamp; reset value 0.
- Undefined: no port, no clamp, no limit_hit.

Decomposition:
- Package qc_seq_pkg: state enum encoding (OFF..RUN), GAIN_WIDTH/DELAY_LEN2 defaults, and a function for the clamped signed step toward a target.
- One sub-module qc_tick_gen: decimation counter producing tick, reset to 0, so the same tick can be shared with the mixer.

Test Plan:
- From OFF, request en=1, gain=1000, delay=100, step=250 -> SET_DELAY; QC_delay=100, QC_enable=1; 8192 ticks at QC_gain=0; then gain 250, 500, 750, 1000 on successive ticks; RUN, cfg_ready=1.
- In RUN (gain 1000), request delay=200 -> gain 750..0 over 4 ticks; QC_delay changes only when QC_gain=0; settle; ramp back to 1000.
- In RUN, request gain=-700 with the same delay, step=500 -> 500, 0, -500, -700; no delay change, no settle.
- Request en=0 from gain 1000, step=0 -> gain decreases 1 per tick to 0, then QC_enable=0, state=OFF.
- Assert a_resetn=0 mid-RAMP_UP -> all outputs return to reset values without waiting for a clock; a clean restart follows.
- Hold cfg_valid with new values during SETTLE -> not accepted until RUN, then processed.
